// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and helpers for the CCFF chain loader.
//   state_t         - loader FSM states
//   words_per_pass  - bitstream words needed to fill the chain once
//   last_word_bits  - number of useful bits in the final word of a pass
package ccff_chain_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int words_per_pass(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    function automatic int last_word_bits(input int chain_len, input int word_w);
        return chain_len - (words_per_pass(chain_len, word_w) - 1) * word_w;
    endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Word-to-bit serializer for the CCFF loader.
// Holds one bitstream word and shifts it out LSB-first, one bit per cycle.
// A new word is fetched while the last held bit is leaving, so a steady
// stream produces no bubbles.
// Ports:
//   prog_clk, prog_reset_n - clock, synchronous active-low reset
//   run                    - loader is in its RUN state
//   words_owed             - more words are needed for the current pass
//   last_word              - next accepted word is the last of the pass
//   bs_valid, bs_data      - upstream word stream
//   bs_ready               - word accepted this edge when bs_valid is also 1
//   accept                 - bs_valid & bs_ready
//   shift                  - a held bit leaves on this edge
//   head                   - bit presented to the chain head (0 when idle)
module ccff_word_serializer #(
    parameter int WORD_W    = 8,
    parameter int LAST_BITS = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              run,
    input  logic              words_owed,
    input  logic              last_word,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              accept,
    output logic              shift,
    output logic              head
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] hold;
    logic [CNT_W-1:0]  hold_cnt;
    logic [CNT_W-1:0]  load_cnt;

    assign shift    = run && (hold_cnt != '0);
    // Refill either from empty or while the final held bit is shifting out.
    assign bs_ready = run && words_owed &&
                      ((hold_cnt == '0) || ((hold_cnt == CNT_W'(1)) && shift));
    assign accept   = bs_ready && bs_valid;
    assign head     = shift ? hold[0] : 1'b0;
    // The final word of a pass may carry fewer useful bits; the rest are dropped.
    assign load_cnt = last_word ? CNT_W'(LAST_BITS) : CNT_W'(WORD_W);

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            hold     <= '0;
            hold_cnt <= '0;
        end else if (accept) begin
            hold     <= bs_data;
            hold_cnt <= load_cnt;
        end else if (shift) begin
            hold     <= hold >> 1;
            hold_cnt <= hold_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// CCFF daisy-chain loader. Serialises bitstream words onto ccff_head,
// drives the chain shift enable, and optionally replays the stream a
// second time while comparing the returning ccff_tail bits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; verify latched on start
// RUN   | shifting a pass (pass 0 = load, pass 1 = verify replay)
// DONE  | one-cycle done pulse, then back to IDLE
//
// Ports:
//   prog_clk, prog_reset_n - clock, synchronous active-low reset
//   start, verify          - begin a load (verify=1 adds a compare pass)
//   bs_valid/bs_data/bs_ready - bitstream word stream, bit 0 first
//   ccff_head, ccff_shift_en  - chain serial input and shift enable
//   ccff_tail              - serial output of the last chain flop
//   busy, done             - activity flag and completion pulse
//   error, err_idx         - sticky verify mismatch and first bad bit index
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8,
    parameter int IDX_W     = $clog2(CHAIN_LEN) + 1
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify,
    input  logic              bs_valid,
    input  logic [WORD_W-1:0] bs_data,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [IDX_W-1:0]  err_idx
);

    import ccff_chain_loader_pkg::*;

    localparam int WPP       = words_per_pass(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = last_word_bits(CHAIN_LEN, WORD_W);
    localparam int WC_W      = $clog2(WPP + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHAIN_LEN - 1);

    state_t           state;
    logic             verify_q;
    logic             pass;
    logic [IDX_W-1:0] bit_idx;
    logic [WC_W-1:0]  word_cnt;

    logic words_owed;
    logic last_word;
    logic accept;
    logic shift;

    assign words_owed    = word_cnt < WC_W'(WPP);
    assign last_word     = word_cnt == WC_W'(WPP - 1);
    assign ccff_shift_en = shift;

    ccff_word_serializer #(
        .WORD_W    (WORD_W),
        .LAST_BITS (LAST_BITS)
    ) u_ser (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .run          (state == RUN),
        .words_owed   (words_owed),
        .last_word    (last_word),
        .bs_valid     (bs_valid),
        .bs_data      (bs_data),
        .bs_ready     (bs_ready),
        .accept       (accept),
        .shift        (shift),
        .head         (ccff_head)
    );

    always_ff @(posedge prog_clk) begin
        if (!prog_reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            verify_q <= 1'b0;
            pass     <= 1'b0;
            bit_idx  <= '0;
            word_cnt <= '0;
            error    <= 1'b0;
            err_idx  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        verify_q <= verify;
                        pass     <= 1'b0;
                        bit_idx  <= '0;
                        word_cnt <= '0;
                        error    <= 1'b0;
                        err_idx  <= '0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        word_cnt <= word_cnt + WC_W'(1);
                    end
                    if (shift) begin
                        // The replay pass pushes the same stream, so the bit
                        // leaving the tail at index k must equal the head bit.
                        if (pass && (ccff_tail != ccff_head)) begin
                            error <= 1'b1;
                            if (!error) begin
                                err_idx <= bit_idx;
                            end
                        end
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (verify_q && !pass) begin
                                pass     <= 1'b1;
                                word_cnt <= '0;
                            end else begin
                                state <= DONE;
                                done  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
module tb_ccff_chain_loader;

    localparam int CHAIN_LEN = 10;
    localparam int WORD_W    = 4;
    localparam int IDX_W     = 5;

    logic             prog_clk = 1'b0;
    logic             prog_reset_n;
    logic             start;
    logic             verify;
    logic             bs_valid;
    logic [WORD_W-1:0] bs_data;
    logic             bs_ready;
    logic             ccff_head;
    logic             ccff_shift_en;
    logic             ccff_tail;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] err_idx;

    int checks   = 0;
    int failures = 0;

    // Chain model: a plain shift register clocked by the shift enable.
    logic [CHAIN_LEN-1:0] chain_q = '0;
    logic                 tail_flip;
    assign ccff_tail = chain_q[CHAIN_LEN-1] ^ tail_flip;

    always @(posedge prog_clk)
        if (ccff_shift_en) chain_q <= {chain_q[CHAIN_LEN-2:0], ccff_head};

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(
        .CHAIN_LEN (CHAIN_LEN),
        .WORD_W    (WORD_W)
    ) dut (
        .prog_clk      (prog_clk),
        .prog_reset_n  (prog_reset_n),
        .start         (start),
        .verify        (verify),
        .bs_valid      (bs_valid),
        .bs_data       (bs_data),
        .bs_ready      (bs_ready),
        .ccff_head     (ccff_head),
        .ccff_shift_en (ccff_shift_en),
        .ccff_tail     (ccff_tail),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_idx       (err_idx)
    );

    // Stimulus source and run observations.
    logic [WORD_W-1:0] src [0:7];
    int                n_src;
    logic [19:0]       flip_mask;

    logic [19:0] r_heads;
    int r_nshift, r_first, r_last, r_done_cnt, r_done_cyc, r_extra, r_head_bad;
    bit r_timeout;
    logic r_rst_busy, r_rst_shift, r_rst_ready, r_rst_err, r_rst_done;

    // Reference: first CHAIN_LEN bits of the word stream, bit k = k-th shifted.
    function automatic logic [9:0] stream_of(input logic [3:0] a, b, c);
        return {c[1:0], b, a};
    endfunction

    // Chain after a full pass: the first shifted bit sits at the tail.
    function automatic logic [9:0] chain_of(input logic [9:0] s);
        logic [9:0] r;
        for (int k = 0; k < 10; k++) r[9-k] = s[k];
        return r;
    endfunction

    task automatic set_src(input logic [3:0] a, b, c, input bit twice);
        src[0] = a; src[1] = b; src[2] = c;
        src[3] = a; src[4] = b; src[5] = c;
        n_src = twice ? 6 : 3;
    endtask

    // Runs one load: drives start and the word stream, records what the
    // chain interface does cycle by cycle. Cycle 0 is the start cycle.
    task automatic run_load(input bit vfy, input int gap_after, input int gap_len,
                            input int rst_at, input int start_again);
        int  c, gap_left, wi, abort_cyc;
        bit  aborted;
        r_heads = '0; r_nshift = 0; r_first = -1; r_last = -1;
        r_done_cnt = 0; r_done_cyc = -1; r_extra = 0; r_head_bad = 0; r_timeout = 0;
        gap_left = 0; wi = 0; aborted = 0; abort_cyc = 0;
        @(negedge prog_clk);
        start = 1'b1; verify = vfy; bs_valid = 1'b0; tail_flip = 1'b0;
        for (c = 1; c < 400; c++) begin
            @(negedge prog_clk);
            start = (c == start_again);
            if (aborted && c == abort_cyc + 1) begin
                r_rst_busy = busy; r_rst_shift = ccff_shift_en; r_rst_ready = bs_ready;
                r_rst_err = error; r_rst_done = done;
                prog_reset_n = 1'b1;
            end
            if (gap_left > 0 && bs_ready) begin
                bs_valid = 1'b0; gap_left--;
            end else if (wi < n_src) begin
                bs_valid = 1'b1; bs_data = src[wi];
            end else begin
                bs_valid = 1'b1; bs_data = 4'hF;
            end
            if (bs_valid && bs_ready) begin
                if (wi >= n_src) r_extra++;
                wi++;
                if (wi == gap_after + 1) gap_left = gap_len;
            end
            if (ccff_shift_en) begin
                if (r_nshift < 20) r_heads[r_nshift] = ccff_head;
                tail_flip = (r_nshift < 20) ? flip_mask[r_nshift] : 1'b0;
                if (r_first < 0) r_first = c;
                r_last = c;
                r_nshift++;
                if (r_nshift == rst_at) begin
                    prog_reset_n = 1'b0; aborted = 1; abort_cyc = c;
                end
            end else begin
                tail_flip = 1'b0;
                if (ccff_head !== 1'b0) r_head_bad++;
            end
            if (done) begin r_done_cnt++; r_done_cyc = c; end
            if (r_done_cnt > 0 && c >= r_done_cyc + 3) break;
            if (aborted && c >= abort_cyc + 6) break;
        end
        if (c >= 400) r_timeout = 1;
        bs_valid = 1'b0; start = 1'b0; tail_flip = 1'b0;
    endtask

    task automatic test_reset();
        prog_reset_n = 1'b0;
        repeat (3) @(negedge prog_clk);
        checks++; if ({busy, done, error, bs_ready, ccff_shift_en, ccff_head} !== 6'b0)
            begin failures++; $display("FAIL reset_outputs got=%b want=000000",
                {busy, done, error, bs_ready, ccff_shift_en, ccff_head}); end
        checks++; if (err_idx !== '0)
            begin failures++; $display("FAIL reset_err_idx got=%0d want=0", err_idx); end
        prog_reset_n = 1'b1;
        @(negedge prog_clk);
    endtask

    task automatic test_basic_load();
        logic [9:0] s;
        set_src(4'h5, 4'hA, 4'h3, 0); flip_mask = '0;
        s = stream_of(4'h5, 4'hA, 4'h3);
        run_load(0, -1, 0, 0, -1);
        checks++; if (r_timeout) begin failures++; $display("FAIL basic_timeout got=1 want=0"); end
        checks++; if (r_heads[9:0] !== 10'b1110100101)
            begin failures++; $display("FAIL basic_head_seq got=%b want=1110100101", r_heads[9:0]); end
        checks++; if (r_nshift != 10)
            begin failures++; $display("FAIL basic_nshift got=%0d want=10", r_nshift); end
        checks++; if (r_first != 2)
            begin failures++; $display("FAIL basic_first_shift got=%0d want=2", r_first); end
        checks++; if (r_last - r_first + 1 != 10)
            begin failures++; $display("FAIL basic_window got=%0d want=10", r_last - r_first + 1); end
        checks++; if (r_done_cnt != 1 || r_done_cyc != r_last + 1)
            begin failures++; $display("FAIL basic_done got=%0d@%0d want=1@%0d", r_done_cnt, r_done_cyc, r_last + 1); end
        checks++; if (chain_q !== chain_of(s))
            begin failures++; $display("FAIL basic_chain got=%b want=%b", chain_q, chain_of(s)); end
        checks++; if (error !== 1'b0 || r_head_bad != 0)
            begin failures++; $display("FAIL basic_err_head got=%b/%0d want=0/0", error, r_head_bad); end
    endtask

    task automatic test_stall();
        logic [9:0] s;
        set_src(4'h5, 4'hA, 4'h3, 0); flip_mask = '0;
        s = stream_of(4'h5, 4'hA, 4'h3);
        chain_q = '0;
        run_load(0, 0, 3, 0, -1);
        checks++; if (r_last - r_first + 1 != 13 || r_nshift != 10)
            begin failures++; $display("FAIL stall_window got=%0d/%0d want=13/10", r_last - r_first + 1, r_nshift); end
        checks++; if (r_head_bad != 0)
            begin failures++; $display("FAIL stall_head got=%0d want=0", r_head_bad); end
        checks++; if (chain_q !== chain_of(s) || r_heads[9:0] !== s)
            begin failures++; $display("FAIL stall_chain got=%b want=%b", chain_q, chain_of(s)); end
    endtask

    task automatic test_verify(input bit inject);
        logic [9:0] s;
        set_src(4'h5, 4'hA, 4'h3, 1);
        flip_mask = '0;
        if (inject) begin flip_mask[16] = 1'b1; flip_mask[18] = 1'b1; end
        s = stream_of(4'h5, 4'hA, 4'h3);
        run_load(1, -1, 0, 0, -1);
        checks++; if (r_nshift != 20 || r_done_cnt != 1 || r_timeout)
            begin failures++; $display("FAIL verify_shifts got=%0d/%0d want=20/1", r_nshift, r_done_cnt); end
        checks++; if (r_heads !== {s, s})
            begin failures++; $display("FAIL verify_heads got=%b want=%b", r_heads, {s, s}); end
        checks++; if (chain_q !== chain_of(s))
            begin failures++; $display("FAIL verify_chain got=%b want=%b", chain_q, chain_of(s)); end
        checks++; if (error !== inject || err_idx !== (inject ? 5'd6 : 5'd0))
            begin failures++; $display("FAIL verify_error got=%b/%0d want=%b/%0d", error, err_idx, inject, inject ? 6 : 0); end
    endtask

    task automatic test_reset_abort();
        logic [9:0] s;
        set_src(4'h9, 4'h6, 4'h2, 0); flip_mask = '0;
        s = stream_of(4'h9, 4'h6, 4'h2);
        run_load(0, -1, 0, 5, -1);
        checks++; if ({r_rst_busy, r_rst_shift, r_rst_ready, r_rst_err, r_rst_done} !== 5'b0)
            begin failures++; $display("FAIL abort_outputs got=%b want=00000",
                {r_rst_busy, r_rst_shift, r_rst_ready, r_rst_err, r_rst_done}); end
        checks++; if (r_done_cnt != 0)
            begin failures++; $display("FAIL abort_done got=%0d want=0", r_done_cnt); end
        run_load(0, -1, 0, 0, -1);
        checks++; if (r_nshift != 10 || r_done_cnt != 1 || chain_q !== chain_of(s))
            begin failures++; $display("FAIL abort_reload got=%0d/%0d/%b want=10/1/%b",
                r_nshift, r_done_cnt, chain_q, chain_of(s)); end
    endtask

    task automatic test_back_to_back();
        set_src(4'hC, 4'h3, 4'h1, 0); flip_mask = '0;
        run_load(0, -1, 0, 0, 4);
        checks++; if (r_extra != 0)
            begin failures++; $display("FAIL extra_word got=%0d want=0", r_extra); end
        checks++; if (r_done_cnt != 1 || r_nshift != 10 || busy !== 1'b0)
            begin failures++; $display("FAIL start_ignored got=%0d/%0d/%b want=1/10/0", r_done_cnt, r_nshift, busy); end
    endtask

    task automatic test_random();
        logic [3:0] w [3];
        logic [9:0] s;
        bit vfy, exp_err;
        int exp_idx, ga, gl;
        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 3; j++) w[j] = 4'($urandom);
            vfy = 1'($urandom_range(0, 1));
            ga = int'($urandom_range(0, 3)) - 1;
            gl = int'($urandom_range(0, 3));
            flip_mask = 20'($urandom & $urandom & $urandom);
            set_src(w[0], w[1], w[2], vfy);
            s = stream_of(w[0], w[1], w[2]);
            exp_err = 0; exp_idx = 0;
            if (vfy)
                for (int k = 9; k >= 0; k--)
                    if (flip_mask[10 + k]) begin exp_err = 1; exp_idx = k; end
            run_load(vfy, ga, gl, 0, -1);
            checks++; if (r_nshift != (vfy ? 20 : 10) || r_done_cnt != 1 || r_extra != 0)
                begin failures++; $display("FAIL rand%0d_flow got=%0d/%0d/%0d", it, r_nshift, r_done_cnt, r_extra); end
            checks++; if (r_heads[9:0] !== s || (vfy && r_heads[19:10] !== s))
                begin failures++; $display("FAIL rand%0d_heads got=%b want=%b", it, r_heads, s); end
            checks++; if (chain_q !== chain_of(s))
                begin failures++; $display("FAIL rand%0d_chain got=%b want=%b", it, chain_q, chain_of(s)); end
            checks++; if (error !== exp_err || err_idx !== 5'(exp_idx))
                begin failures++; $display("FAIL rand%0d_error got=%b/%0d want=%b/%0d", it, error, err_idx, exp_err, exp_idx); end
        end
    endtask

    initial begin
        prog_reset_n = 1'b0; start = 1'b0; verify = 1'b0;
        bs_valid = 1'b0; bs_data = '0; tail_flip = 1'b0; flip_mask = '0; n_src = 0;
        test_reset();
        test_basic_load();
        test_stall();
        test_verify(0);
        test_verify(1);
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
